// File: rtl/topk_result_drain.sv
// Drains a captured top-K neighbor snapshot as a ranked stream, nearest first.
// One entry per cycle is handed out through a valid/ready handshake, followed by a one-cycle done pulse.
module topk_result_drain #(
  parameter int K         = 8,
  parameter int BIT_WIDTH = 16,
  parameter int ID_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [K-1:0]            load_mask,
  input  logic [K*BIT_WIDTH-1:0]  load_dist,
  input  logic [K*ID_WIDTH-1:0]   load_id,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BIT_WIDTH-1:0]    out_dist,
  output logic [ID_WIDTH-1:0]     out_id,
  output logic [$clog2(K)-1:0]    out_rank,
  output logic                    out_last,
  input  logic                    abort,
  output logic                    done
);

  localparam int RW = $clog2(K);

  typedef enum logic [1:0] {IDLE, DRAIN, FINISH} state_t;

  state_t                        state_q, state_d;
  logic [K-1:0]                  pending_q, pending_d;
  logic [K-1:0][BIT_WIDTH-1:0]   dist_q, dist_d;
  logic [K-1:0][ID_WIDTH-1:0]    id_q, id_d;
  logic [RW-1:0]                 rank_q, rank_d;

  logic [RW-1:0]                 selIdx;
  logic [BIT_WIDTH-1:0]          selDist;
  logic                          selFound;
  logic                          lastOne;

  // Minimum search over pending slots; strict less-than keeps the lowest index on ties
  always_comb begin
    selIdx   = '0;
    selDist  = '0;
    selFound = 1'b0;
    for (int i = 0; i < K; i++) begin
      if (pending_q[i] && (!selFound || dist_q[i] < selDist)) begin
        selFound = 1'b1;
        selIdx   = RW'(i);
        selDist  = dist_q[i];
      end
    end
  end

  assign lastOne = (pending_q != '0) && ((pending_q & (pending_q - K'(1))) == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      dist_q    <= '0;
      id_q      <= '0;
      rank_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      dist_q    <= dist_d;
      id_q      <= id_d;
      rank_q    <= rank_d;
    end
  end

  // Abort takes priority over the output handshake; in IDLE it is simply ignored
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    dist_d     = dist_q;
    id_d       = id_q;
    rank_d     = rank_q;
    load_ready = 1'b0;
    out_valid  = 1'b0;
    out_dist   = '0;
    out_id     = '0;
    out_rank   = '0;
    out_last   = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          pending_d = load_mask;
          dist_d    = load_dist;
          id_d      = load_id;
          rank_d    = '0;
          state_d   = (load_mask != '0) ? DRAIN : FINISH;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_dist  = selDist;
        out_id    = id_q[selIdx];
        out_rank  = rank_q;
        out_last  = lastOne;
        if (abort) begin
          pending_d = '0;
          state_d   = IDLE;
        end else if (out_ready) begin
          pending_d[selIdx] = 1'b0;
          rank_d            = rank_q + RW'(1);
          if (lastOne) state_d = FINISH;
        end
      end
      FINISH: begin
        done      = !abort;
        pending_d = '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
